// File: rtl/wb_pkg.sv
// wb_pkg
// Shared definitions for the register-file write-port arbiter:
//   - REG_ADDR_BITS / DATA_BITS : default register address and datapath widths
//   - wbEntry_t                 : one MDU result queue entry {valid, rd, data}
//   - wbSel_t / wbSelect()      : writeback result source encoding and decode
package wb_pkg;

    localparam int REG_ADDR_BITS = 5;
    localparam int DATA_BITS     = 32;

    typedef struct packed {
        logic                     valid;
        logic [REG_ADDR_BITS-1:0] rd;
        logic [DATA_BITS-1:0]     data;
    } wbEntry_t;

    typedef enum logic [1:0] {
        WB_SEL_ALU = 2'd0,
        WB_SEL_MEM = 2'd1,
        WB_SEL_PC  = 2'd2
    } wbSel_t;

    // The link value (PC+4) overrides the memory/ALU choice.
    function automatic wbSel_t wbSelect(input logic aluMemOrPc, input logic memToReg);
        wbSel_t sel;
        sel = WB_SEL_ALU;
        if (aluMemOrPc) begin
            sel = WB_SEL_PC;
        end else if (memToReg) begin
            sel = WB_SEL_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/wb_result_queue.sv
// wb_result_queue
// DEPTH-entry FIFO holding MDU results waiting for the register-file write
// port. Each entry carries a valid bit that can be cleared in place by the
// parallel rd-match invalidate port (WAW squash), so a squashed entry keeps
// its FIFO slot and is later popped without a write.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   push/pushValid/pushRd/pushData  enqueue (pushValid=0 enqueues a dead entry)
//   pop                     dequeue the head
//   kill/killRd             invalidate every stored entry whose rd == killRd
//   headPresent             queue not empty
//   headValid/headRd/headData       head entry (headValid gated by headPresent)
//   count                   occupied entries
module wb_result_queue
    import wb_pkg::*;
#(
    parameter int NBits       = DATA_BITS,
    parameter int RegAddrBits = REG_ADDR_BITS,
    parameter int DEPTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pushValid,
    input  logic [RegAddrBits-1:0]       pushRd,
    input  logic [NBits-1:0]             pushData,
    input  logic                         pop,
    input  logic                         kill,
    input  logic [RegAddrBits-1:0]       killRd,
    output logic                         headPresent,
    output logic                         headValid,
    output logic [RegAddrBits-1:0]       headRd,
    output logic [NBits-1:0]             headData,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PtrBits = $clog2(DEPTH);
    localparam int CntBits = $clog2(DEPTH+1);

    logic [DEPTH-1:0]       validMem;
    logic [RegAddrBits-1:0] rdMem   [DEPTH];
    logic [NBits-1:0]       dataMem [DEPTH];
    logic [DEPTH-1:0]       killHit;
    logic [PtrBits-1:0]     wrPtr;
    logic [PtrBits-1:0]     rdPtr;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : gKill
            assign killHit[gi] = kill && (rdMem[gi] == killRd);
        end
    endgenerate

    assign headPresent = (count != '0);
    assign headValid   = headPresent && validMem[rdPtr];
    assign headRd      = rdMem[rdPtr];
    assign headData    = dataMem[rdPtr];

    // Payload needs no reset: it is only observed through a set valid bit.
    always_ff @(posedge clk) begin
        if (push) begin
            rdMem[wrPtr]   <= pushRd;
            dataMem[wrPtr] <= pushData;
        end
    end

    // The slot being written is empty, so its kill match (stale rd) is
    // irrelevant; a same-cycle squash arrives already folded into pushValid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            validMem <= '0;
        end else begin
            validMem <= validMem & ~killHit;
            if (push) begin
                validMem[wrPtr] <= pushValid;
            end
        end
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + PtrBits'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PtrBits'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CntBits'(1);
                2'b01:   count <= count - CntBits'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Owns the single register-file write port. The in-order pipeline WB result
// always wins; MDU results are queued (wb_result_queue) and drained in cycles
// the pipeline does not write. A pipeline write to rd squashes every queued
// MDU result for the same rd, so an older MDU result can never overwrite it.
// Optional feature: define WB_STARVE_GUARD_EN to add a starvation guard that
// stalls the pipeline for one cycle after a valid head has waited
// STARVE_LIMIT cycles; without it pipe_stall is tied to 0.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   pipe_valid/pipe_reg_write/pipe_rd   WB-stage instruction
//   MemtoReg/ALUMemOrPC/PC_4/ALUResult/MemoryData   WB result select/data
//   mdu_valid/mdu_rd/mdu_data/mdu_ready MDU result handshake
//   rf_we/rf_waddr/rf_wdata       registered register-file write
//   pipe_stall                    hold WB stage this cycle
//   q_count                       occupied queue entries
module wb_port_arbiter
    import wb_pkg::*;
#(
    parameter int NBits        = DATA_BITS,
    parameter int RegAddrBits  = REG_ADDR_BITS,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pipe_valid,
    input  logic                         pipe_reg_write,
    input  logic [RegAddrBits-1:0]       pipe_rd,
    input  logic                         MemtoReg,
    input  logic                         ALUMemOrPC,
    input  logic [NBits-1:0]             PC_4,
    input  logic [NBits-1:0]             ALUResult,
    input  logic [NBits-1:0]             MemoryData,
    input  logic                         mdu_valid,
    input  logic [RegAddrBits-1:0]       mdu_rd,
    input  logic [NBits-1:0]             mdu_data,
    output logic                         mdu_ready,
    output logic                         rf_we,
    output logic [RegAddrBits-1:0]       rf_waddr,
    output logic [NBits-1:0]             rf_wdata,
    output logic                         pipe_stall,
    output logic [$clog2(DEPTH+1)-1:0]   q_count
);

    localparam int CntBits = $clog2(DEPTH+1);

    wbSel_t                 pipeSel;
    logic [NBits-1:0]       pipeData;
    logic                   pipeWantsWrite;
    logic                   pipeWrite;
    logic                   qPush;
    logic                   qPushValid;
    logic                   qPop;
    logic                   headPresent;
    logic                   headValid;
    logic [RegAddrBits-1:0] headRd;
    logic [NBits-1:0]       headData;
    logic                   headDrain;

    always_comb begin
        pipeSel  = wbSelect(ALUMemOrPC, MemtoReg);
        pipeData = ALUResult;
        case (pipeSel)
            WB_SEL_PC:  pipeData = PC_4;
            WB_SEL_MEM: pipeData = MemoryData;
            default:    pipeData = ALUResult;
        endcase
    end

    assign pipeWantsWrite = pipe_valid && pipe_reg_write && (pipe_rd != '0);
    assign pipeWrite      = pipeWantsWrite && !pipe_stall;

    // Ready looks only at the count: a full queue refuses even if it pops
    // this cycle, keeping mdu_ready off every datapath path.
    assign mdu_ready  = (q_count != CntBits'(DEPTH));
    // Results for r0 are accepted but dropped.
    assign qPush      = mdu_valid && mdu_ready && (mdu_rd != '0);
    assign qPushValid = !(pipeWrite && (mdu_rd == pipe_rd));

    assign headDrain  = headValid && !pipeWrite;
    // A dead (squashed) head leaves even when the pipeline owns the port.
    assign qPop       = headPresent && (!headValid || !pipeWrite);

    wb_result_queue #(
        .NBits       (NBits),
        .RegAddrBits (RegAddrBits),
        .DEPTH       (DEPTH)
    ) uQueue (
        .clk         (clk),
        .reset       (reset),
        .push        (qPush),
        .pushValid   (qPushValid),
        .pushRd      (mdu_rd),
        .pushData    (mdu_data),
        .pop         (qPop),
        .kill        (pipeWrite),
        .killRd      (pipe_rd),
        .headPresent (headPresent),
        .headValid   (headValid),
        .headRd      (headRd),
        .headData    (headData),
        .count       (q_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (pipeWrite) begin
            rf_we    <= 1'b1;
            rf_waddr <= pipe_rd;
            rf_wdata <= pipeData;
        end else if (headDrain) begin
            rf_we    <= 1'b1;
            rf_waddr <= headRd;
            rf_wdata <= headData;
        end else begin
            rf_we    <= 1'b0;
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int StarveBits = $clog2(STARVE_LIMIT+1);

    logic [StarveBits-1:0] starveCnt;

    // The stall lands on the STARVE_LIMIT-th waiting cycle itself: the
    // counter holds the number of cycles already lost to the pipeline.
    assign pipe_stall = headValid && pipeWantsWrite &&
                        (starveCnt == StarveBits'(STARVE_LIMIT-1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starveCnt <= '0;
        end else if (!headPresent || qPop) begin
            starveCnt <= '0;
        end else if (headValid && pipeWrite) begin
            starveCnt <= starveCnt + StarveBits'(1);
        end
    end
`else
    logic [31:0] unusedStarveLimit;

    assign unusedStarveLimit = STARVE_LIMIT;
    assign pipe_stall        = 1'b0;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
`timescale 1ns/1ps
module tb_wb_port_arbiter;
    import wb_pkg::*;

    localparam int NB    = 32;
    localparam int RB    = 5;
    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int CB    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          pipe_valid, pipe_reg_write, MemtoReg, ALUMemOrPC;
    logic [RB-1:0] pipe_rd, mdu_rd;
    logic [NB-1:0] PC_4, ALUResult, MemoryData, mdu_data;
    logic          mdu_valid;
    logic          mdu_ready, rf_we, pipe_stall;
    logic [RB-1:0] rf_waddr;
    logic [NB-1:0] rf_wdata;
    logic [CB-1:0] q_count;

    always #5 clk = ~clk;

    wb_port_arbiter #(
        .NBits(NB), .RegAddrBits(RB), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_reg_write(pipe_reg_write), .pipe_rd(pipe_rd),
        .MemtoReg(MemtoReg), .ALUMemOrPC(ALUMemOrPC), .PC_4(PC_4),
        .ALUResult(ALUResult), .MemoryData(MemoryData),
        .mdu_valid(mdu_valid), .mdu_rd(mdu_rd), .mdu_data(mdu_data), .mdu_ready(mdu_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pipe_stall(pipe_stall), .q_count(q_count)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic          we;
        logic [RB-1:0] addr;
        logic [NB-1:0] data;
    } rfExp_t;

    rfExp_t   expQ[$];     // expected register-file state, one per cycle
    wbEntry_t mq[$];       // model of pending MDU results, oldest first
    int       starveWait = 0;
    logic [RB-1:0] lastAddr = '0;
    logic [NB-1:0] lastData = '0;

    task automatic modelStep();
        logic          rawPw, stall, pw, doPop, headOk;
        logic [NB-1:0] pdata;
        rfExp_t        e;
        wbEntry_t      ent;
        int            sz;
        sz     = mq.size();
        headOk = (sz > 0) && mq[0].valid;
        rawPw  = pipe_valid && pipe_reg_write && (pipe_rd != 0);
        stall  = 1'b0;
`ifdef WB_STARVE_GUARD_EN
        stall  = headOk && rawPw && (starveWait == LIMIT-1);
`endif
        pw     = rawPw && !stall;
        pdata  = ALUMemOrPC ? PC_4 : (MemtoReg ? MemoryData : ALUResult);

        check("mdu_ready", 64'(mdu_ready), 64'(sz != DEPTH));
        check("q_count", 64'(q_count), 64'(sz));
        check("pipe_stall", 64'(pipe_stall), 64'(stall));

        if (pw) begin
            e.we = 1'b1; e.addr = pipe_rd; e.data = pdata;
        end else if (headOk) begin
            e.we = 1'b1; e.addr = mq[0].rd; e.data = mq[0].data;
        end else begin
            e.we = 1'b0; e.addr = lastAddr; e.data = lastData;
        end
        lastAddr = e.addr;
        lastData = e.data;
        expQ.push_back(e);

        // Pop decision is made on the head as it stood at the start of the cycle.
        doPop = (sz > 0) && (!mq[0].valid || !pw);
        if (doPop) starveWait = 0;
        else if (headOk && pw) starveWait++;

        if (pw) begin
            foreach (mq[i]) if (mq[i].rd == pipe_rd) mq[i].valid = 1'b0;
        end
        if (doPop) void'(mq.pop_front());
        if (mdu_valid && (sz != DEPTH) && (mdu_rd != 0)) begin
            ent.valid = !(pw && (mdu_rd == pipe_rd));
            ent.rd    = mdu_rd;
            ent.data  = mdu_data;
            mq.push_back(ent);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) modelStep();
    end

    // ---------------- monitor ----------------
    rfExp_t mon;
    always @(posedge clk) begin
        #2;
        if (!reset && expQ.size() > 0) begin
            mon = expQ.pop_front();
            check("rf_we", 64'(rf_we), 64'(mon.we));
            check("rf_waddr", 64'(rf_waddr), 64'(mon.addr));
            check("rf_wdata", 64'(rf_wdata), 64'(mon.data));
            if (rf_we) $display("t=%0t rf write r%0d = 0x%08h", $time, rf_waddr, rf_wdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setIdle();
        pipe_valid = 0; pipe_reg_write = 0; pipe_rd = '0; MemtoReg = 0; ALUMemOrPC = 0;
        PC_4 = '0; ALUResult = '0; MemoryData = '0;
        mdu_valid = 0; mdu_rd = '0; mdu_data = '0;
    endtask

    task automatic setPipe(input logic [RB-1:0] rd, input logic [NB-1:0] alu);
        pipe_valid = 1; pipe_reg_write = 1; pipe_rd = rd; ALUResult = alu;
        MemtoReg = 0; ALUMemOrPC = 0;
    endtask

    task automatic setMdu(input logic [RB-1:0] rd, input logic [NB-1:0] data);
        mdu_valid = 1; mdu_rd = rd; mdu_data = data;
    endtask

    logic wasStalled;

    initial begin
        setIdle();
        tick();
        tick();
        check("reset rf_we", 64'(rf_we), 64'd0);
        check("reset rf_waddr", 64'(rf_waddr), 64'd0);
        check("reset rf_wdata", 64'(rf_wdata), 64'd0);
        check("reset q_count", 64'(q_count), 64'd0);
        check("reset pipe_stall", 64'(pipe_stall), 64'd0);
        reset = 0;

        // Pipe priority over a same-cycle MDU push
        setIdle(); setPipe(5'd3, 32'h11); setMdu(5'd5, 32'h22); tick();
        setIdle(); tick(); tick();

        // Result select: PC_4 overrides MemtoReg, then memory data
        setIdle(); setPipe(5'd31, 32'h1); ALUMemOrPC = 1; MemtoReg = 1; PC_4 = 32'h0040_0008; tick();
        setIdle(); setPipe(5'd4, 32'h2); MemtoReg = 1; MemoryData = 32'hDEAD; tick();
        setIdle(); tick();

        // Full queue under continuous pipe writes, 5th offer must wait
        for (int i = 0; i < 5; i++) begin
            setIdle(); setPipe(5'd1, 32'h100 + i); setMdu(5'(10 + i), 32'h200 + i); tick();
        end
        setIdle(); setMdu(5'd14, 32'h204); tick();
        setIdle(); setMdu(5'd14, 32'h204); tick();
        setIdle(); repeat (7) tick();

        // WAW squash: queued r7 result is overtaken by a pipe write to r7
        setIdle(); setPipe(5'd2, 32'h33); setMdu(5'd7, 32'hAA); tick();
        setIdle(); setPipe(5'd7, 32'hBB); tick();
        setIdle(); repeat (3) tick();

        // Same-cycle squash: MDU result for the rd the pipe writes now
        setIdle(); setPipe(5'd6, 32'h66); setMdu(5'd6, 32'h77); tick();
        setIdle(); repeat (3) tick();

        // r0 results are dropped
        setIdle(); setMdu(5'd0, 32'h99); tick();
        setIdle(); repeat (2) tick();

        // Asynchronous reset with three results queued
        for (int i = 0; i < 3; i++) begin
            setIdle(); setPipe(5'd2, 32'h300 + i); setMdu(5'(20 + i), 32'h400 + i); tick();
        end
        setIdle();
        reset = 1;
        expQ.delete(); mq.delete(); starveWait = 0; lastAddr = '0; lastData = '0;
        #1;
        check("async reset rf_we", 64'(rf_we), 64'd0);
        check("async reset q_count", 64'(q_count), 64'd0);
        tick(); tick();
        reset = 0;
        repeat (5) tick();

        // One queued result facing a continuously writing pipeline
        setIdle(); setPipe(5'd1, 32'h500); setMdu(5'd9, 32'h600); tick();
        setIdle(); setPipe(5'd1, 32'h500);
        repeat (11) tick();
        setIdle(); repeat (3) tick();

        // Randomized traffic; a stalled pipe instruction is held
        wasStalled = 0;
        for (int i = 0; i < 400; i++) begin
            if (!wasStalled) begin
                pipe_valid     = ($urandom_range(0, 3) != 0);
                pipe_reg_write = ($urandom_range(0, 4) != 0);
                pipe_rd        = RB'($urandom_range(0, 7));
                MemtoReg       = 1'($urandom_range(0, 1));
                ALUMemOrPC     = ($urandom_range(0, 3) == 0);
                PC_4           = $urandom;
                ALUResult      = $urandom;
                MemoryData     = $urandom;
            end
            mdu_valid = 1'($urandom_range(0, 1));
            mdu_rd    = RB'($urandom_range(0, 7));
            mdu_data  = $urandom;
            #1 wasStalled = pipe_stall;
            tick();
        end

        setIdle(); repeat (DEPTH + 4) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
